reg_write_arbiter: RTL and testbench
====================================

Name: reg_write_arbiter

Overview:
- Shares one 4-bit storage register (clk/reset/in_data/out_data style) between NUM_REQ requesters.
- Arbitrates write requests and sequences each write as accept, write, readback-check.
- Reports a commit pulse with a pass/fail result.
- Sits between requesters and the register's in_data/load path; the register's out_data feeds back for verification.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- DATA_W, 4, register data width.
- ID_W, $clog2(NUM_REQ), requester index width (derived, not overridden).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- req_valid  input  NUM_REQ  per-requester write request.
- req_data  input  NUM_REQ*DATA_W  write data; requester i uses bits [i*DATA_W +: DATA_W].
- req_ready  output  NUM_REQ  one-hot accept; a transfer occurs when req_valid[i] and req_ready[i] are high at a rising edge.
- reg_we  output  1  write strobe to the shared register.
- reg_wdata  output  DATA_W  data driven to the register in_data.
- reg_q  input  DATA_W  register out_data, used for readback.
- busy  output  1  high while a transaction is in WRITE or CHECK.
- commit_valid  output  1  one-cycle pulse marking the end of a transaction.
- commit_id  output  ID_W  requester index of the committed transaction.
- commit_err  output  1  readback mismatch flag; qualified by commit_valid.

Behaviour:
- Reset (reset=0, asynchronous):
  - State goes to IDLE; the round-robin pointer goes to 0.
  - reg_we=0, reg_wdata=0, busy=0, commit_valid=0, commit_id=0, commit_err=0.
  - req_ready=0 while reset is asserted.
- States: IDLE, WRITE, CHECK (encoding in the package).
- IDLE:
  - If no req_valid is high: req_ready=0 and the state stays IDLE.
  - Otherwise the winner is the first asserted requester at or after the pointer, searching upward with wrap.
  - req_ready is combinational in IDLE: one-hot on the winner, 0 in every other state.
  - At the edge: latch winner id and its data, then go to WRITE.
- WRITE:
  - reg_we=1 and reg_wdata=latched data for exactly one cycle; busy=1.
  - Next state is CHECK.
- CHECK:
  - reg_we=0; busy=1.
  - Compare reg_q against the latched data.
  - At the edge: commit_valid=1 for the following cycle, commit_id=latched id, commit_err=(reg_q != latched data).
  - Pointer becomes (id+1) mod NUM_REQ; next state is IDLE.
- Timing:
  - commit_valid is registered and is asserted during the first IDLE cycle after CHECK.
  - A new accept may happen in that same cycle.
  - Latency from accept edge to commit_valid is 2 cycles; peak throughput is 1 write per 3 cycles.
- Handshake rules:
  - Requesters hold req_valid and req_data stable until accepted.
  - Data sampled only at the accept edge; later changes to req_data have no effect.
  - Dropping req_valid before accept is allowed; no transfer occurs.
- Boundary conditions:
  - All requesters asserted: strict rotation 0,1,2,3,0,… from reset.
  - A single requester held high is accepted every 3 cycles.
  - Pointer wrap: NUM_REQ-1 is followed by 0.
  - Reset mid-WRITE or mid-CHECK: the transaction is dropped, no commit_valid is produced, reg_we goes to 0 immediately.
  - The register holding a reset value (readback mismatch) produces commit_err=1; the FSM still completes normally.
  - Non-power-of-two NUM_REQ: ids ≥ NUM_REQ are never produced.

Optional Feature:
- Macro: REG_ARB_FIXED_PRIO_EN.
- Defined: fixed priority, lowest asserted index wins; the pointer is not instantiated.
- Undefined (default): round-robin as described above.
- Handshake, FSM and latency are identical in both builds.

Decomposition:
- Package reg_arb_pkg:
  - State encoding constants ST_IDLE=2'd0, ST_WRITE=2'd1, ST_CHECK=2'd2.
  - Default widths; clog2 helper function for ID_W.
- Sub-module rr_pick: combinational picker.
  - Inputs: req vector, pointer.
  - Outputs: one-hot grant, index, any-request flag.
  - Under REG_ARB_FIXED_PRIO_EN it ignores the pointer.
- Top level: FSM, data/id latch, commit registers.

Test Plan:
- Reset released, req_valid=4'b0000 for 10 cycles -> req_ready=0, reg_we=0, busy=0, commit_valid never asserted.
- req_valid=4'b0100, req_data[11:8]=4'b1010, register connected -> req_ready=4'b0100 for one cycle; next cycle reg_we=1 with reg_wdata=4'b1010; commit_valid pulses 2 cycles after accept with commit_id=2, commit_err=0.
- req_valid=4'b1111 held, data i=4'h(i+5) -> accept order 0,1,2,3,0; accepts are spaced 3 cycles apart; each commit_id matches the accept; reg_wdata=5,6,7,8,5. Under REG_ARB_FIXED_PRIO_EN the same stimulus yields commit_id always 0.
- reg_q forced to 4'b0000 while 4'b0101 is written by requester 1 -> commit_valid=1, commit_id=1, commit_err=1; next request still served.
- reset driven low during WRITE -> reg_we drops asynchronously, no commit_valid; after release the pointer is 0 and requester 0 wins if req_valid=4'b1001.
- req_valid[3] raised then dropped while busy -> no accept for 3; req_data changed after accept -> reg_wdata unchanged.

Source files
------------

// File: rtl/reg_write_arbiter_pkg.sv
// reg_arb_pkg: shared constants for reg_write_arbiter.
//   - FSM state encoding (IDLE / WRITE / CHECK).
//   - Default requester count and data width.
//   - clog2 helper used to derive the requester index width.
package reg_arb_pkg;

  localparam int DEF_NUM_REQ = 4;
  localparam int DEF_DATA_W  = 4;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_WRITE = 2'd1;
  localparam logic [1:0] ST_CHECK = 2'd2;

  // Ceiling log2, never less than 1 so a 1-bit index is always available.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) begin
      result++;
    end
    if (result < 1) begin
      result = 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/reg_write_arbiter_rr_pick.sv
// rr_pick: combinational request picker for reg_write_arbiter.
//   Default build : round-robin, first asserted request at or after ptr_i,
//                   searching upward with wrap.
//   REG_ARB_FIXED_PRIO_EN defined : fixed priority, lowest asserted index
//                   wins and ptr_i is ignored.
// Ports:
//   req_i   [N-1:0]     request vector
//   ptr_i   [ID_W-1:0]  round-robin start index
//   grant_o [N-1:0]     one-hot grant (all zero when no request)
//   idx_o   [ID_W-1:0]  binary index of the granted request
//   any_o               at least one request asserted
module rr_pick
  import reg_arb_pkg::*;
#(
  parameter int  N    = DEF_NUM_REQ,
  localparam int ID_W = clog2(N)
) (
  input  logic [N-1:0]    req_i,
  input  logic [ID_W-1:0] ptr_i,
  output logic [N-1:0]    grant_o,
  output logic [ID_W-1:0] idx_o,
  output logic            any_o
);

  logic [ID_W-1:0] pick_idx;
  logic            found;

`ifdef REG_ARB_FIXED_PRIO_EN
  // Pointer is a don't-care in this build; fold it into a sink.
  logic unused_ptr;
  assign unused_ptr = ^ptr_i;

  always_comb begin
    pick_idx = '0;
    found    = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (!found && req_i[k]) begin
        found    = 1'b1;
        pick_idx = ID_W'(k);
      end
    end
  end
`else
  // Candidate k positions after the pointer, wrapped into 0..N-1.
  function automatic int wrap_idx(input int base, input int offset);
    return (base + offset) % N;
  endfunction

  always_comb begin
    pick_idx = '0;
    found    = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (!found && req_i[wrap_idx(int'(ptr_i), k)]) begin
        found    = 1'b1;
        pick_idx = ID_W'(wrap_idx(int'(ptr_i), k));
      end
    end
  end
`endif

  assign any_o = found;
  assign idx_o = pick_idx;

  for (genvar gi = 0; gi < N; gi++) begin : g_grant
    assign grant_o[gi] = found && (pick_idx == ID_W'(gi));
  end

endmodule

// File: rtl/reg_write_arbiter.sv
// reg_write_arbiter: shares one DATA_W-bit storage register between NUM_REQ
// requesters. Each accepted write is sequenced IDLE -> WRITE -> CHECK; the
// register's output is read back in CHECK and a one-cycle commit pulse
// reports the requester id and a mismatch flag.
// Optional build macro: REG_ARB_FIXED_PRIO_EN (fixed priority, no pointer).
// Ports:
//   clk           rising-edge clock
//   reset         asynchronous active-low reset
//   req_valid     per-requester write request
//   req_data      packed write data, requester i at [i*DATA_W +: DATA_W]
//   req_ready     one-hot accept, only in IDLE
//   reg_we        write strobe to the shared register (WRITE only)
//   reg_wdata     data to the register in_data
//   reg_q         register out_data, used for readback
//   busy          high in WRITE or CHECK
//   commit_valid  one-cycle end-of-transaction pulse
//   commit_id     requester index of the committed transaction
//   commit_err    readback mismatch, qualified by commit_valid
module reg_write_arbiter
  import reg_arb_pkg::*;
#(
  parameter int  NUM_REQ = DEF_NUM_REQ,
  parameter int  DATA_W  = DEF_DATA_W,
  localparam int ID_W    = clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      reg_we,
  output logic [DATA_W-1:0]         reg_wdata,
  input  logic [DATA_W-1:0]         reg_q,
  output logic                      busy,
  output logic                      commit_valid,
  output logic [ID_W-1:0]           commit_id,
  output logic                      commit_err
);

  logic [1:0]         state_q, state_d;
  logic [ID_W-1:0]    id_q, id_d;
  logic [DATA_W-1:0]  data_q, data_d;
  logic               commit_valid_q, commit_valid_d;
  logic [ID_W-1:0]    commit_id_q, commit_id_d;
  logic               commit_err_q, commit_err_d;

  logic [ID_W-1:0]    ptr_sel;
  logic [NUM_REQ-1:0] pick_grant;
  logic [ID_W-1:0]    pick_idx;
  logic               pick_any;

  logic [DATA_W-1:0]  req_word [NUM_REQ];

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
    assign req_word[gi] = req_data[gi*DATA_W +: DATA_W];
  end

`ifdef REG_ARB_FIXED_PRIO_EN
  assign ptr_sel = '0;
`else
  logic [ID_W-1:0] ptr_q, ptr_d;

  // The pointer advances past the requester just served, so it moves only
  // when a transaction completes; a reset mid-transaction leaves it at 0.
  always_comb begin
    ptr_d = ptr_q;
    if (state_q == ST_CHECK) begin
      ptr_d = (id_q == ID_W'(NUM_REQ - 1)) ? '0 : id_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr_sel = ptr_q;
`endif

  rr_pick #(
    .N (NUM_REQ)
  ) u_pick (
    .req_i   (req_valid),
    .ptr_i   (ptr_sel),
    .grant_o (pick_grant),
    .idx_o   (pick_idx),
    .any_o   (pick_any)
  );

  always_comb begin
    state_d        = state_q;
    id_d           = id_q;
    data_d         = data_q;
    commit_valid_d = 1'b0;
    commit_id_d    = commit_id_q;
    commit_err_d   = commit_err_q;
    case (state_q)
      ST_IDLE: begin
        if (pick_any) begin
          id_d    = pick_idx;
          data_d  = req_word[pick_idx];
          state_d = ST_WRITE;
        end
      end
      ST_WRITE: begin
        state_d = ST_CHECK;
      end
      ST_CHECK: begin
        commit_valid_d = 1'b1;
        commit_id_d    = id_q;
        commit_err_d   = (reg_q != data_q);
        state_d        = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= ST_IDLE;
      id_q           <= '0;
      data_q         <= '0;
      commit_valid_q <= 1'b0;
      commit_id_q    <= '0;
      commit_err_q   <= 1'b0;
    end else begin
      state_q        <= state_d;
      id_q           <= id_d;
      data_q         <= data_d;
      commit_valid_q <= commit_valid_d;
      commit_id_q    <= commit_id_d;
      commit_err_q   <= commit_err_d;
    end
  end

  // Gating with reset keeps req_ready low while reset is held even though
  // the state register already reads IDLE.
  assign req_ready    = (reset && (state_q == ST_IDLE)) ? pick_grant : '0;
  assign reg_we       = (state_q == ST_WRITE);
  assign reg_wdata    = reg_we ? data_q : '0;
  assign busy         = (state_q == ST_WRITE) || (state_q == ST_CHECK);
  assign commit_valid = commit_valid_q;
  assign commit_id    = commit_id_q;
  assign commit_err   = commit_err_q;

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Self-checking bench for reg_write_arbiter (NUM_REQ=4, DATA_W=4).
// A table of full transactions is replayed back to back, followed by
// hand-written sequences for readback error, late data / valid changes,
// and reset in the middle of a transaction.
module tb_reg_write_arbiter;

  logic        clk;
  logic        reset;
  logic [3:0]  req_valid;
  logic [15:0] req_data;
  logic [3:0]  req_ready;
  logic        reg_we;
  logic [3:0]  reg_wdata;
  logic [3:0]  reg_q;
  logic        busy;
  logic        commit_valid;
  logic [1:0]  commit_id;
  logic        commit_err;

  int tests;
  int errors;

  // Shared storage register plus a hook to force its output to zero.
  logic [3:0] reg_store;
  logic       force_zero;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      reg_store <= '0;
    end else if (reg_we) begin
      reg_store <= reg_wdata;
    end
  end

  assign reg_q = force_zero ? 4'b0000 : reg_store;

  reg_write_arbiter #(
    .NUM_REQ (4),
    .DATA_W  (4)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_data     (req_data),
    .req_ready    (req_ready),
    .reg_we       (reg_we),
    .reg_wdata    (reg_wdata),
    .reg_q        (reg_q),
    .busy         (busy),
    .commit_valid (commit_valid),
    .commit_id    (commit_id),
    .commit_err   (commit_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [3:0]  valid;
    logic [15:0] data;
    logic [1:0]  exp_id;
    logic [3:0]  exp_wdata;
  } vec_t;

  vec_t vecs [10];

  initial begin
    logic [3:0] exp_ready;

    // Round-robin expectations, pointer starting at 0 after reset.
    vecs[0] = '{4'b0100, 16'h0A00, 2'd2, 4'hA};
    vecs[1] = '{4'b1111, 16'h8765, 2'd3, 4'h8};
    vecs[2] = '{4'b1111, 16'h8765, 2'd0, 4'h5};
    vecs[3] = '{4'b1111, 16'h8765, 2'd1, 4'h6};
    vecs[4] = '{4'b1111, 16'h8765, 2'd2, 4'h7};
    vecs[5] = '{4'b1111, 16'h8765, 2'd3, 4'h8};
    vecs[6] = '{4'b1111, 16'h8765, 2'd0, 4'h5};
    vecs[7] = '{4'b1001, 16'hC003, 2'd3, 4'hC};
    vecs[8] = '{4'b0011, 16'h0091, 2'd0, 4'h1};
    vecs[9] = '{4'b0001, 16'h000E, 2'd0, 4'hE};
`ifdef REG_ARB_FIXED_PRIO_EN
    // Fixed priority: lowest asserted requester always wins.
    for (int i = 0; i < 10; i++) begin
      for (int k = 3; k >= 0; k--) begin
        if (vecs[i].valid[k]) begin
          vecs[i].exp_id    = 2'(k);
          vecs[i].exp_wdata = vecs[i].data[k*4 +: 4];
        end
      end
    end
`endif

    tests      = 0;
    errors     = 0;
    force_zero = 1'b0;
    reset      = 1'b0;
    req_valid  = 4'b1111;
    req_data   = 16'h8765;

    // Reset values, with requests already asserted.
    repeat (2) @(posedge clk);
    #1;
    check("reset_ready", req_ready, 4'b0000);
    check("reset_we", reg_we, 1'b0);
    check("reset_wdata", reg_wdata, 4'h0);
    check("reset_busy", busy, 1'b0);
    check("reset_commit_valid", commit_valid, 1'b0);
    check("reset_commit_id", commit_id, 2'd0);
    check("reset_commit_err", commit_err, 1'b0);

    req_valid = 4'b0000;
    reset     = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk);
      #1;
      check("idle_ready", req_ready, 4'b0000);
      check("idle_we", reg_we, 1'b0);
      check("idle_busy", busy, 1'b0);
      check("idle_commit_valid", commit_valid, 1'b0);
    end

    // Back-to-back transactions; each starts in the commit cycle of the last.
    for (int i = 0; i < 10; i++) begin
      req_valid = vecs[i].valid;
      req_data  = vecs[i].data;
      exp_ready = 4'b0001 << vecs[i].exp_id;
      #1;
      check("vec_ready", req_ready, exp_ready);
      @(posedge clk);
      #1;
      check("vec_write_we", reg_we, 1'b1);
      check("vec_write_wdata", reg_wdata, vecs[i].exp_wdata);
      check("vec_write_busy", busy, 1'b1);
      check("vec_write_ready", req_ready, 4'b0000);
      check("vec_commit_pulse_len", commit_valid, 1'b0);
      @(posedge clk);
      #1;
      check("vec_check_we", reg_we, 1'b0);
      check("vec_check_busy", busy, 1'b1);
      @(posedge clk);
      #1;
      check("vec_commit_valid", commit_valid, 1'b1);
      check("vec_commit_id", commit_id, vecs[i].exp_id);
      check("vec_commit_err", commit_err, 1'b0);
      check("vec_idle_busy", busy, 1'b0);
      $display("[TB] vec %0d: valid=%b id=%0d err=%0b", i, vecs[i].valid, commit_id, commit_err);
    end
    req_valid = 4'b0000;

    // Readback mismatch: register output held at zero while 5 is written.
    @(posedge clk);
    #1;
    force_zero = 1'b1;
    req_valid  = 4'b0010;
    req_data   = 16'h0050;
    #1;
    check("err_ready", req_ready, 4'b0010);
    @(posedge clk);
    #1;
    check("err_wdata", reg_wdata, 4'h5);
    @(posedge clk);
    #1;
    req_valid = 4'b0000;
    @(posedge clk);
    #1;
    check("err_commit_valid", commit_valid, 1'b1);
    check("err_commit_id", commit_id, 2'd1);
    check("err_commit_err", commit_err, 1'b1);
    $display("[TB] err seq: id=%0d err=%0b", commit_id, commit_err);
    force_zero = 1'b0;
    req_valid  = 4'b0100;
    req_data   = 16'h0900;
    #1;
    check("after_err_ready", req_ready, 4'b0100);
    @(posedge clk);
    #1;
    check("after_err_wdata", reg_wdata, 4'h9);
    req_valid = 4'b0000;
    @(posedge clk);
    @(posedge clk);
    #1;
    check("after_err_commit_valid", commit_valid, 1'b1);
    check("after_err_commit_id", commit_id, 2'd2);
    check("after_err_commit_err", commit_err, 1'b0);
    $display("[TB] after-err seq: id=%0d err=%0b", commit_id, commit_err);

    // Late data change and a transient request on 3 while busy.
    @(posedge clk);
    #1;
    req_valid = 4'b0010;
    req_data  = 16'h0030;
    #1;
    check("late_ready", req_ready, 4'b0010);
    @(posedge clk);
    #1;
    req_data  = 16'hD0F0;
    req_valid = 4'b1000;
    #1;
    check("late_wdata", reg_wdata, 4'h3);
    check("late_ready_busy", req_ready, 4'b0000);
    @(posedge clk);
    #1;
    req_valid = 4'b0000;
    @(posedge clk);
    #1;
    check("late_commit_valid", commit_valid, 1'b1);
    check("late_commit_id", commit_id, 2'd1);
    check("late_commit_err", commit_err, 1'b0);
    $display("[TB] late-change seq: id=%0d err=%0b", commit_id, commit_err);
    @(posedge clk);
    #1;
    check("dropped_no_accept", busy, 1'b0);
    check("dropped_no_we", reg_we, 1'b0);

    // Reset in the middle of a WRITE.
    req_valid = 4'b0100;
    req_data  = 16'hB600;
    #1;
    check("rst_seq_ready", req_ready, 4'b0100);
    @(posedge clk);
    #1;
    check("rst_seq_we_before", reg_we, 1'b1);
    reset     = 1'b0;
    req_valid = 4'b1001;
    req_data  = 16'hB002;
    #1;
    check("rst_seq_we_async", reg_we, 1'b0);
    check("rst_seq_wdata", reg_wdata, 4'h0);
    check("rst_seq_busy", busy, 1'b0);
    check("rst_seq_ready_in_reset", req_ready, 4'b0000);
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      #1;
      check("rst_seq_no_commit", commit_valid, 1'b0);
    end
    reset = 1'b1;
    #1;
    check("rst_seq_ptr_zero_ready", req_ready, 4'b0001);
    @(posedge clk);
    #1;
    check("rst_seq_wdata_after", reg_wdata, 4'h2);
    check("rst_seq_commit_stale", commit_valid, 1'b0);
    req_valid = 4'b0000;
    @(posedge clk);
    @(posedge clk);
    #1;
    check("rst_seq_commit_valid", commit_valid, 1'b1);
    check("rst_seq_commit_id", commit_id, 2'd0);
    check("rst_seq_commit_err", commit_err, 1'b0);
    $display("[TB] reset seq: id=%0d err=%0b", commit_id, commit_err);

    @(posedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
